rr_arb_mux: RTL
===============

Name: rr_arb_mux

Overview:
- Parametrised N-channel selector with a valid/ready handshake on every input channel and on the output, plus a registered output stage.
- Two modes:
  - Direct mode: an external select picks one channel, as the existing combinational muxes do.
  - Round-robin mode: an internal fair arbiter picks the next requesting channel.
- Sits between multiple producers (e.g. forwarding sources, memory-response channels) and a single pipeline consumer. It replaces ad-hoc wide muxes wherever backpressure or fairness is needed.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 16, number of input channels; legal range 2..64.
- SEL_W, $clog2(CHANNELS), select/index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SEL_W  channel index used in direct mode.
- in_data  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel request.
- in_ready  output  CHANNELS  per-channel accept; combinational.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_sel hold a valid beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (synchronous, active-high; clock and reset as decided):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=CHANNELS-1, so channel 0 has first priority.
  - in_ready all 0 while reset is asserted.
- Load enable: load = !out_valid | out_ready. The output register is a single entry; a drain and a refill happen in the same cycle.
- Grant, combinational, one-hot, at most one bit set:
  - Direct mode (mode=0): grant[sel]=in_valid[sel] & (sel<CHANNELS). If sel>=CHANNELS, no grant and nothing is accepted.
  - Round-robin mode (mode=1): the first i with in_valid[i]=1, searching ptr+1, ptr+2, … modulo CHANNELS and ending with ptr itself.
- in_ready = grant & {CHANNELS{load}}. A channel transfers when in_valid[i] & in_ready[i].
- Transfer on the clock edge:
  - out_data <= channel data, out_sel <= index, out_valid <= 1.
  - In round-robin mode, ptr <= granted index.
  - In direct mode, ptr is unchanged.
- If load=1 and no grant: out_valid <= 0; out_data and out_sel hold their old values.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle with out_ready held high.
- Stall (out_valid=1, out_ready=0):
  - out_data and out_sel remain bit-stable.
  - All in_ready=0.
  - ptr is frozen.
- Mode or sel change mid-operation:
  - Affects only the next grant; a held output beat is never altered or dropped.
  - ptr is preserved across mode switches.
- Fairness: in round-robin mode, a channel held valid is granted within CHANNELS transfers.
- Simultaneous drain and refill: in the same edge the old beat is consumed and the new beat loads; there is no bubble.
- Reset mid-stall: the held beat is discarded and out_valid=0 on the next cycle.
- No combinational path from out_ready to out_valid or out_data. The only combinational path is out_ready to in_ready.

Decomposition:
- Shared package holds:
  - MODE_DIRECT=1'b0 and MODE_RR=1'b1 constants.
  - A function returning the index of a one-hot vector.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr[SEL_W]; outputs grant[N] and grant_idx[SEL_W]. Pure combinational rotate, priority-find and unrotate. It is reusable by other arbitrating blocks.
- The top holds the mode mux, the load logic, the output register and the ptr register.

Test Plan:
- Reset, then mode=0, sel=5, in_valid[5]=1, in_data ch5=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=5; in_ready=16'h0020 during the transfer cycle.
- mode=1, all 16 in_valid=1, each channel's data = its index, out_ready=1 for 20 cycles -> out_sel sequence 0,1,…,15,0,1,2,3, with no bubbles.
- mode=1, in_valid=16'h8001, ptr at 0 after one grant -> next grant is 15, then 0, alternating.
- Stall: beat 0x11 on out_data, out_ready=0 for 4 cycles while ch3 is valid with 0x22 -> out_data stays 0x11, all in_ready=0; out_ready=1 -> 0x22 appears on the following cycle.
- Edge select: mode=0, CHANNELS=12 instance, sel=13 with all valid -> in_ready=0 and out_valid falls to 0 after the current beat drains.
- Reset asserted during a stall with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 the next cycle; after release, round-robin grants channel 0 first.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrating selector and its arbiter.
`timescale 1ns/1ps
package rr_arb_mux_pkg;

    localparam logic MODE_DIRECT  = 1'b0;
    localparam logic MODE_RR      = 1'b1;
    localparam int   MAX_CHANNELS = 64;

    // Index of the set bit in a one-hot vector; returns 0 for an all-zero vector.
    function automatic int onehot_to_idx(input logic [MAX_CHANNELS-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping to ptr last.
`timescale 1ns/1ps
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter  int N     = 16,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Walking offsets 1..N from ptr is the rotate / priority-find / unrotate in one pass.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = SEL_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign grant_idx = SEL_W'(onehot_to_idx(MAX_CHANNELS'(grant)));

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready selector with direct or round-robin selection and a one-entry output register.
`timescale 1ns/1ps
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 16,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    ch_data [CHANNELS];
    logic [CHANNELS-1:0] rr_grant;
    logic [SEL_W-1:0]    rr_idx;
    logic [CHANNELS-1:0] direct_grant;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                load;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    rr_arbiter #(.N(CHANNELS)) u_arbiter (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Out-of-range select indices (non power-of-two CHANNELS) never grant.
    always_comb begin
        direct_grant = '0;
        if (int'(sel) < CHANNELS && in_valid[sel]) begin
            direct_grant[sel] = 1'b1;
        end
    end

    always_comb begin
        grant     = (mode == MODE_RR) ? rr_grant : direct_grant;
        grant_idx = (mode == MODE_RR) ? rr_idx : sel;
        load      = !out_valid_q || out_ready;
        in_ready  = reset ? '0 : (grant & {CHANNELS{load}});
    end

    // A load with no grant drops out_valid but keeps the last data/index visible.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (|grant) begin
                out_valid_d = 1'b1;
                out_data_d  = ch_data[grant_idx];
                out_sel_d   = grant_idx;
                if (mode == MODE_RR) begin
                    ptr_d = rr_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= SEL_W'(CHANNELS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
